pred_resolve: RTL and testbench

//  Tracks every fetched instruction's branch prediction from IF until it leaves EX, in program order.
//  At EX, checks the actual branch outcome against the recorded prediction.
//  On a mismatch it redirects fetch and flushes the wrong-path entries.

---
 rtl/pred_resolve_pkg.sv | 11 +
 rtl/pred_fifo.sv | 45 ++++
 rtl/pred_resolve.sv | 89 ++++++++
 tb/tb_pred_resolve.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pred_resolve_pkg.sv
// pred_resolve_pkg: shared XLEN, in-flight prediction entry and resolver FSM state types
package pred_resolve_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_v;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } pred_entry_t;
  typedef enum logic [1:0] {IDLE, RUN, RECOVER} pred_res_state_e;
endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: DEPTH x pred_entry_t sync FIFO; ports: push/din in, pop/dout out (head), clear, count/full/empty status
module pred_fifo
  import pred_resolve_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  pred_entry_t            din,
  output pred_entry_t            dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  pred_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd];
  // Pointers are AW bits wide, so DEPTH being a power of two gives the modulo wrap for free
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push & ~clear) mem[wr] <= din;
endmodule

// File: rtl/pred_resolve.sv
// pred_resolve: tracks IF predictions to EX, resolves them; ports: IF push/full, EX pop/outcome, flush, redirect and predictor update outputs
module pred_resolve
  import pred_resolve_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_push_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic            if_pred_v_i,
  input  logic            if_pred_taken_i,
  input  logic [XLEN-1:0] if_pred_pc_i,
  output logic            if_full_o,
  input  logic            ex_pop_i,
  input  logic            ex_branch_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            flush_i,
  output logic            redirect_v_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            pred_en_o,
  output logic [XLEN-1:0] pred_pc_branch_o,
  output logic [XLEN-1:0] pred_pc_target_o,
  output logic            pred_success_q_o,
  output logic            pred_failed_q_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  pred_res_state_e state, state_nx;
  pred_entry_t head, din;
  logic [CW-1:0] cnt;
  logic full, empty, accept, push_ok, pop_ok, ptaken, wrong, mis, upd;
  assign din = '{pc: if_pc_i, pred_v: if_pred_v_i, pred_taken: if_pred_taken_i, pred_pc: if_pred_pc_i};
  assign push_ok = if_push_i & ~full & accept;
  assign pop_ok = ex_pop_i & ~empty & accept;
  assign ptaken = head.pred_v & head.pred_taken;
  // A non-branch is simply "actually not taken", so a taken prediction on it is wrong too
  assign wrong = (ex_taken_i != ptaken) | (ex_taken_i & ptaken & (ex_target_i != head.pred_pc));
  // flush_i outranks everything: the popped instruction is itself being squashed
  assign mis = pop_ok & wrong & ~flush_i;
  assign upd = pop_ok & ex_branch_i & ~flush_i;
  assign if_full_o = full;
  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_ok),
    .pop     (pop_ok),
    .clear   (flush_i | mis),
    .din     (din),
    .dout    (head),
    .count   (cnt),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = flush_i ? IDLE :
               state == RECOVER ? IDLE :
               mis ? RECOVER :
               state == IDLE ? (push_ok ? RUN : IDLE) :
               (pop_ok & ~push_ok & cnt == CW'(1)) ? IDLE : RUN;
  // Everything between the mispredicted branch and the refetch is wrong-path, so RECOVER accepts nothing
  always_comb
    accept = state != RECOVER;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      redirect_v_o <= 1'b0;
      redirect_pc_o <= '0;
      pred_en_o <= 1'b0;
      pred_pc_branch_o <= '0;
      pred_pc_target_o <= '0;
      pred_success_q_o <= 1'b0;
      pred_failed_q_o <= 1'b0;
    end else begin
      redirect_v_o <= mis;
      if (mis) redirect_pc_o <= ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(4);
      pred_en_o <= upd;
      if (upd) begin
        pred_pc_branch_o <= ex_pc_i;
        pred_pc_target_o <= ex_target_i;
      end
      pred_success_q_o <= upd & head.pred_v & ~wrong;
      pred_failed_q_o <= upd & head.pred_v & wrong;
    end
  ap_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n) !(ex_pop_i && accept && empty));
endmodule

// File: tb/tb_pred_resolve.sv
// tb_pred_resolve: directed plus random stimulus against a queue-based reference model of pred_resolve
module tb_pred_resolve;
  import pred_resolve_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic reset_n = 0;
  logic if_push_i = 0, if_pred_v_i = 0, if_pred_taken_i = 0;
  logic [XLEN-1:0] if_pc_i = '0, if_pred_pc_i = '0;
  logic ex_pop_i = 0, ex_branch_i = 0, ex_taken_i = 0, flush_i = 0;
  logic [XLEN-1:0] ex_pc_i = '0, ex_target_i = '0;
  logic if_full_o, redirect_v_o, pred_en_o, pred_success_q_o, pred_failed_q_o;
  logic [XLEN-1:0] redirect_pc_o, pred_pc_branch_o, pred_pc_target_o;
  int checks = 0, errors = 0;
  pred_resolve #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .if_push_i        (if_push_i),
    .if_pc_i          (if_pc_i),
    .if_pred_v_i      (if_pred_v_i),
    .if_pred_taken_i  (if_pred_taken_i),
    .if_pred_pc_i     (if_pred_pc_i),
    .if_full_o        (if_full_o),
    .ex_pop_i         (ex_pop_i),
    .ex_branch_i      (ex_branch_i),
    .ex_taken_i       (ex_taken_i),
    .ex_pc_i          (ex_pc_i),
    .ex_target_i      (ex_target_i),
    .flush_i          (flush_i),
    .redirect_v_o     (redirect_v_o),
    .redirect_pc_o    (redirect_pc_o),
    .pred_en_o        (pred_en_o),
    .pred_pc_branch_o (pred_pc_branch_o),
    .pred_pc_target_o (pred_pc_target_o),
    .pred_success_q_o (pred_success_q_o),
    .pred_failed_q_o  (pred_failed_q_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic push, input logic [31:0] pc, input logic pv, input logic pt, input logic [31:0] ppc,
                     input logic pop, input logic br, input logic tk, input logic [31:0] epc, input logic [31:0] et,
                     input logic fl);
    if_push_i = push; if_pc_i = pc; if_pred_v_i = pv; if_pred_taken_i = pt; if_pred_pc_i = ppc;
    ex_pop_i = pop; ex_branch_i = br; ex_taken_i = tk; ex_pc_i = epc; ex_target_i = et; flush_i = fl;
    @(negedge clk);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic push(input logic [31:0] pc, input logic pv, input logic pt, input logic [31:0] ppc);
    cyc(1, pc, pv, pt, ppc, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic pop(input logic br, input logic tk, input logic [31:0] epc, input logic [31:0] et, input logic fl);
    cyc(0, 0, 0, 0, 0, 1, br, tk, epc, et, fl);
  endtask
  // Reference model: a queue of in-flight predictions plus a one-cycle recovery flag
  pred_entry_t q[$];
  bit rec;
  logic m_rv, m_en, m_s, m_f;
  logic [31:0] m_rpc, m_bpc, m_tpc;
  always @(posedge clk or negedge reset_n) begin : model
    bit dpush, dpop, w, pt;
    pred_entry_t h;
    if (!reset_n) begin
      q.delete(); rec = 0;
      m_rv = 0; m_en = 0; m_s = 0; m_f = 0; m_rpc = 0; m_bpc = 0; m_tpc = 0;
    end else begin
      dpop = ex_pop_i && q.size() > 0 && !rec;
      dpush = if_push_i && q.size() < DEPTH && !rec;
      h = dpop ? q[0] : '0;
      pt = h.pred_v && h.pred_taken;
      w = dpop && ((ex_taken_i != pt) || (ex_taken_i && pt && ex_target_i != h.pred_pc));
      m_rv = 0; m_en = 0; m_s = 0; m_f = 0;
      if (flush_i) begin
        q.delete(); rec = 0;
      end else if (rec) rec = 0;
      else begin
        if (dpop && ex_branch_i) begin
          m_en = 1; m_bpc = ex_pc_i; m_tpc = ex_target_i;
          m_s = h.pred_v && !w; m_f = h.pred_v && w;
        end
        if (w) begin
          m_rv = 1; m_rpc = ex_taken_i ? ex_target_i : ex_pc_i + 4;
          q.delete(); rec = 1;
        end else begin
          if (dpop) void'(q.pop_front());
          if (dpush) q.push_back('{if_pc_i, if_pred_v_i, if_pred_taken_i, if_pred_pc_i});
        end
      end
    end
  end
  always @(negedge clk)
    if (reset_n) begin
      chk("full", if_full_o, q.size() == DEPTH);
      chk("count", dut.cnt, q.size());
      chk("redirect_v", redirect_v_o, m_rv);
      chk("pred_en", pred_en_o, m_en);
      chk("success", pred_success_q_o, m_s);
      chk("failed", pred_failed_q_o, m_f);
      if (m_rv) chk("redirect_pc", redirect_pc_o, m_rpc);
      if (m_en) begin
        chk("pc_branch", pred_pc_branch_o, m_bpc);
        chk("pc_target", pred_pc_target_o, m_tpc);
      end
    end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_full", if_full_o, 0);
    chk("rst_rv", redirect_v_o, 0);
    chk("rst_en", pred_en_o, 0);
    chk("rst_rpc", redirect_pc_o, 0);
    reset_n = 1;
    push(32'h100, 0, 0, 0);
    pop(1, 0, 32'h100, 32'h104, 0);
    chk("t1_en", pred_en_o, 1);
    chk("t1_succ", pred_success_q_o, 0);
    chk("t1_fail", pred_failed_q_o, 0);
    chk("t1_rv", redirect_v_o, 0);
    push(32'h200, 1, 1, 32'h400);
    pop(1, 1, 32'h200, 32'h400, 0);
    chk("t2_succ", pred_success_q_o, 1);
    chk("t2_tgt", pred_pc_target_o, 32'h400);
    chk("t2_rv", redirect_v_o, 0);
    push(32'h200, 1, 1, 32'h400);
    push(32'h204, 1, 1, 32'h400);
    push(32'h208, 1, 1, 32'h400);
    pop(1, 0, 32'h200, 32'h400, 0);
    chk("t3_fail", pred_failed_q_o, 1);
    chk("t3_rv", redirect_v_o, 1);
    chk("t3_rpc", redirect_pc_o, 32'h204);
    chk("t3_cnt", dut.cnt, 0);
    push(32'h300, 0, 0, 0);
    chk("t3_drop", dut.cnt, 0);
    push(32'h200, 1, 1, 32'h400);
    pop(1, 1, 32'h200, 32'h500, 0);
    chk("t4_fail", pred_failed_q_o, 1);
    chk("t4_rpc", redirect_pc_o, 32'h500);
    idle();
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 0, 0, 0);
    chk("t5_full", if_full_o, 1);
    push(32'h20, 0, 0, 0);
    chk("t5_cnt4", dut.cnt, 4);
    pop(0, 0, 32'h10, 0, 0);
    chk("t5_cnt3", dut.cnt, 3);
    cyc(1, 32'h24, 0, 0, 0, 1, 0, 0, 32'h14, 0, 0);
    chk("t5_pp", dut.cnt, 3);
    pop(0, 0, 32'h18, 0, 0);
    pop(0, 0, 32'h1c, 0, 0);
    pop(0, 0, 32'h24, 0, 0);
    chk("t5_wrap", dut.u_fifo.rd, 1);
    chk("t5_empty", dut.cnt, 0);
    push(32'h200, 1, 1, 32'h400);
    pop(1, 0, 32'h200, 32'h400, 1);
    chk("t6_rv", redirect_v_o, 0);
    chk("t6_en", pred_en_o, 0);
    chk("t6_cnt", dut.cnt, 0);
    push(32'h300, 0, 0, 0);
    push(32'h304, 0, 0, 0);
    pop(1, 1, 32'h300, 32'h600, 0);
    chk("t6_pulse", redirect_v_o, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_rv", redirect_v_o, 0);
    chk("t6_rst_en", pred_en_o, 0);
    chk("t6_rst_fail", pred_failed_q_o, 0);
    chk("t6_rst_cnt", dut.cnt, 0);
    @(negedge clk);
    reset_n = 1;
    for (int n = 0; n < 3000; n++) begin
      pred_entry_t h;
      logic pu, po, tk, br, fl;
      logic [31:0] epc, et;
      h = q.size() > 0 ? q[0] : '0;
      pu = $urandom_range(0, 2) != 0;
      po = q.size() > 0 && $urandom_range(0, 1) == 1;
      tk = $urandom_range(0, 1) == 1;
      br = tk | ($urandom_range(0, 1) == 1);
      epc = h.pc;
      et = !tk ? epc + 4 : ($urandom_range(0, 3) == 0 ? 32'h500 : h.pred_pc);
      fl = $urandom_range(0, 39) == 0;
      cyc(pu, 32'($urandom_range(0, 63)) << 2, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1 ? 32'h400 : 32'h500, po, br, tk, epc, et, fl);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
